uart_tx_fifo: RTL and testbench

//  UART transmitter, 8N1, LSB first, idle-high line, with a small write FIFO.

---
 rtl/uart_tx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first, idle-high) fed by a small write FIFO.
// Latency: a byte written into an empty, idle block is popped one edge later and the
//   start bit begins on that same edge; queued bytes follow with no idle gap.
// Backpressure: tx_full is high while FIFO_DEPTH bytes are queued; a tx_start seen
//   while full is dropped and latches tx_ovf until reset.
// Ports:
//   clk50m   in   system clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   tx_data  in   [7:0] byte to queue, sampled with tx_start
//   tx_start in   one-cycle write strobe
//   tx_full  out  FIFO holds FIFO_DEPTH bytes
//   tx_ovf   out  sticky overflow flag
//   tx_idle  out  FSM idle and FIFO empty
//   tx       out  registered serial line
module uart_tx_fifo #(
   parameter int FCLK       = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk50m,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_full,
   output logic       tx_ovf,
   output logic       tx_idle,
   output logic       tx
);

   localparam int CLKS_PER_BIT = FCLK / BAUD;
   localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int CW           = AW + 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------
   state_t          state;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   // ---------------------------------------------------------------
   // Next-state values
   // ---------------------------------------------------------------
   state_t          state_nxt;
   logic [BW-1:0]   baud_nxt;
   logic [2:0]      bit_nxt;
   logic [7:0]      shift_nxt;
   logic [CW-1:0]   count_nxt;
   logic            tx_nxt;
   logic            push;
   logic            pop;
   logic            bit_end;
   logic            fifo_has_data;

   // tx_full is registered and always equals (count == FIFO_DEPTH), so a write in
   // the same cycle as a pop from a full FIFO is still dropped.
   assign push          = tx_start & ~tx_full;
   assign bit_end       = (baud_cnt == BAUD_LAST);
   assign fifo_has_data = (count != '0);

   // ---------------------------------------------------------------
   // FSM next state and datapath
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      pop       = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (fifo_has_data) begin
               pop       = 1'b1;
               shift_nxt = mem[rd_ptr];
               baud_nxt  = '0;
               state_nxt = S_START;
            end
         end

         S_START: begin
            if (bit_end) begin
               baud_nxt  = '0;
               bit_nxt   = 3'd0;
               state_nxt = S_DATA;
            end else begin
               baud_nxt  = baud_cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_nxt  = '0;
               shift_nxt = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end else begin
                  bit_nxt   = bit_idx + 3'd1;
               end
            end else begin
               baud_nxt  = baud_cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               baud_nxt = '0;
               // Chain straight into the next start bit when more data waits.
               if (fifo_has_data) begin
                  pop       = 1'b1;
                  shift_nxt = mem[rd_ptr];
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The line level is computed from the next state so the tx flop changes on the
   // same edge as the FSM; DATA uses the post-shift value so each bit appears the
   // moment its bit period begins.
   always_comb begin
      tx_nxt = 1'b1;
      unique case (state_nxt)
         S_START: tx_nxt = 1'b0;
         S_DATA:  tx_nxt = shift_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   always_comb begin
      count_nxt = count;
      unique case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // ---------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tx       <= 1'b1;
         tx_full  <= 1'b0;
         tx_idle  <= 1'b1;
         tx_ovf   <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shift    <= shift_nxt;
         count    <= count_nxt;
         tx       <= tx_nxt;
         tx_full  <= (count_nxt == DEPTH_C);
         tx_idle  <= (state_nxt == S_IDLE) && (count_nxt == '0);
         if (tx_start && tx_full) begin
            tx_ovf <= 1'b1;
         end
         // Pointer width is log2(FIFO_DEPTH), so the increments wrap naturally.
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset: the pointers and count define which entries are valid.
   always_ff @(posedge clk50m) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   // 50 MHz / 2.9 Mbaud truncates to 17 clocks per bit: a short, non-integer-ratio
   // bit time that keeps the run small while exercising the division.
   localparam int FCLK  = 50_000_000;
   localparam int BAUD  = 2_900_000;
   localparam int DEPTH = 4;
   localparam int CPB   = 17;
   localparam int FRAME = 10 * CPB;

   logic       clk50m = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_full;
   logic       tx_ovf;
   logic       tx_idle;
   logic       tx;

   uart_tx_fifo #(.FCLK(FCLK), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_full  (tx_full),
      .tx_ovf   (tx_ovf),
      .tx_idle  (tx_idle),
      .tx       (tx)
   );

   always #10 clk50m = ~clk50m;

   // Number of rising edges so far; read only on falling edges.
   int unsigned pcyc = 0;
   always @(posedge clk50m) pcyc <= pcyc + 1;

   typedef struct {
      logic [7:0]  b;
      int unsigned cyc;
   } frame_t;

   frame_t     exp_q[$];      // frames the model says will start, with start edge
   logic [7:0] m_fifo[$];     // bytes queued but not yet on the line
   int         m_rem = 0;     // edges left until the current frame completes
   bit         m_ovf = 1'b0;

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, pcyc);
      end
   endtask

   // Reference model: one call per rising edge, using pre-edge state.
   // A frame occupies FRAME edges; the next queued byte starts on the edge that
   // ends the previous frame, or on the first edge it is seen queued while quiet.
   task automatic model_edge(input bit st, input logic [7:0] d);
      bit     was_full;
      frame_t f;
      was_full = (m_fifo.size() == DEPTH);
      if (m_rem <= 1 && m_fifo.size() > 0) begin
         f.b   = m_fifo.pop_front();
         f.cyc = pcyc + 1;
         exp_q.push_back(f);
         m_rem = FRAME;
      end else if (m_rem > 0) begin
         m_rem--;
      end
      if (st) begin
         if (was_full) m_ovf = 1'b1;
         else          m_fifo.push_back(d);
      end
   endtask

   function automatic bit model_quiet();
      return (m_rem == 0) && (m_fifo.size() == 0);
   endfunction

   // Drive one cycle from a falling edge, then check the flags at the next one.
   task automatic cyc_step(input bit st, input logic [7:0] d);
      tx_start = st;
      tx_data  = d;
      model_edge(st, d);
      @(negedge clk50m);
      tx_start = 1'b0;
      check("tx_full", 32'(tx_full), 32'(m_fifo.size() == DEPTH));
      check("tx_idle", 32'(tx_idle), 32'(model_quiet()));
      check("tx_ovf",  32'(tx_ovf),  32'(m_ovf));
      if (m_rem == 0) check("tx_quiet_line", 32'(tx), 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc_step(1'b0, 8'h00);
   endtask

   task automatic drain();
      while (!model_quiet()) cyc_step(1'b0, 8'h00);
      idle_cycles(3);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset(input int hold);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_tx",      32'(tx),      32'd1);
      check("rst_tx_idle", 32'(tx_idle), 32'd1);
      check("rst_tx_full", 32'(tx_full), 32'd0);
      check("rst_tx_ovf",  32'(tx_ovf),  32'd0);
      m_fifo.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      repeat (hold) @(negedge clk50m);
      rst_n = 1'b1;
   endtask

   // Line monitor: decodes frames off tx and compares with the scoreboard.
   initial begin : monitor
      frame_t      f;
      bit          have;
      bit          abort;
      logic [9:0]  bits;
      int unsigned s;
      int          w;
      forever begin
         @(negedge clk50m);
         if (rst_n && tx === 1'b0) begin
            s     = pcyc;
            abort = 1'b0;
            have  = 1'b0;
            bits  = '0;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL frame_unexpected: start bit seen at edge %0d, none expected", s);
            end else begin
               f    = exp_q.pop_front();
               have = 1'b1;
               check("frame_start_edge", f.cyc, s);
            end
            for (int b = 0; b < 10; b++) begin
               w = (b == 0) ? CPB / 2 : CPB;
               for (int i = 0; i < w; i++) begin
                  @(negedge clk50m);
                  if (!rst_n) abort = 1'b1;
               end
               if (abort) break;
               bits[b] = tx;
            end
            if (!abort && have) begin
               check("start_bit", 32'(bits[0]), 32'd0);
               check("data_byte", 32'(bits[8:1]), 32'(f.b));
               check("stop_bit",  32'(bits[9]), 32'd1);
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] lb [3];
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'hA5;

      // Power-on reset held for 1 us.
      repeat (50) @(negedge clk50m);
      check("por_tx",      32'(tx),      32'd1);
      check("por_tx_idle", 32'(tx_idle), 32'd1);
      check("por_tx_full", 32'(tx_full), 32'd0);
      check("por_tx_ovf",  32'(tx_ovf),  32'd0);
      rst_n = 1'b1;
      idle_cycles(4);

      // Single byte 0x55.
      cyc_step(1'b1, 8'h55);
      drain();

      // Three bytes whose frames are decoded off the line.
      for (int i = 0; i < 3; i++) begin
         cyc_step(1'b1, lb[i]);
         idle_cycles(5);
      end
      drain();

      // Burst of four on consecutive cycles.
      for (int i = 1; i <= 4; i++) cyc_step(1'b1, 8'(i));
      drain();

      // Overflow: line busy, then five writes in five cycles.
      cyc_step(1'b1, 8'hC3);
      idle_cycles(20);
      for (int i = 0; i < 5; i++) cyc_step(1'b1, 8'(8'h10 + i));
      drain();

      // Reset during data bit 3 of 0x35 (bit 3 is 0), with two bytes still queued.
      cyc_step(1'b1, 8'h35);
      cyc_step(1'b1, 8'hAA);
      cyc_step(1'b1, 8'hBB);
      idle_cycles(4 * CPB + CPB / 2 - 1);
      check("pre_reset_data_bit3", 32'(tx), 32'd0);
      do_reset(3);
      idle_cycles(2 * FRAME);
      cyc_step(1'b1, 8'h96);
      drain();

      // Randomised traffic: sparse, then dense enough to fill and overflow.
      for (int i = 0; i < 2000; i++)
         cyc_step($urandom_range(0, 199) == 0, 8'($urandom));
      drain();
      for (int i = 0; i < 2500; i++)
         cyc_step($urandom_range(0, 29) == 0, 8'($urandom));
      drain();

      check("frames_outstanding", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
